verilog_task_triangle_gen: RTL and testbench



---
 rtl/verilog_task_triangle_pkg.sv | 20 ++
 rtl/verilog_task_tick_gen.sv | 28 ++
 rtl/verilog_task_triangle_gen.sv | 83 ++++++++
 tb/tb_verilog_task_triangle_gen.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/verilog_task_triangle_pkg.sv
// Shared types and default constants for the triangle-wave generator and its prescaler.
package verilog_task_triangle_pkg;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

    localparam int DEF_DATA_WIDTH = 12;
    localparam int DEF_MIN_VAL    = 0;
    localparam int DEF_MAX_VAL    = 4095;
    localparam int DEF_STEP       = 1;
    localparam int DEF_CLK_DIV    = 1;

    // Counter width for a 0..n-1 counter. It is never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/verilog_task_tick_gen.sv
// Update prescaler: counts 0..CLK_DIV-1 and pulses tick_o during the last count.
module verilog_task_tick_gen
    import verilog_task_triangle_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic ref_clk,
    input  logic rstn,
    output logic tick_o
);

    localparam int CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = (cnt_q == LAST);
        cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ref_clk or posedge rstn) begin
        if (rstn) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/verilog_task_triangle_gen.sv
// Free-running triangle-wave generator that ramps MIN_VAL..MAX_VAL..MIN_VAL.
// Define VERILOG_TASK_TRIANGLE_PRESCALER_EN to update only once every CLK_DIV cycles.
module verilog_task_triangle_gen
    import verilog_task_triangle_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MIN_VAL    = DEF_MIN_VAL,
    parameter int MAX_VAL    = DEF_MAX_VAL,
    parameter int STEP       = DEF_STEP,
    parameter int CLK_DIV    = DEF_CLK_DIV
) (
    input  logic                  ref_clk,
    input  logic                  rstn,
    output logic [DATA_WIDTH-1:0] triangle_wave
);

    generate
        if (MAX_VAL <= MIN_VAL || STEP < 1 || STEP > MAX_VAL - MIN_VAL || CLK_DIV < 1 ||
            64'(MAX_VAL) >= (64'd1 << DATA_WIDTH)) begin : g_bad_params
            $fatal(1, "verilog_task_triangle_gen: illegal parameter combination");
        end
    endgenerate

    localparam logic [DATA_WIDTH-1:0] MIN_W      = DATA_WIDTH'(MIN_VAL);
    localparam logic [DATA_WIDTH-1:0] MAX_W      = DATA_WIDTH'(MAX_VAL);
    localparam logic [DATA_WIDTH-1:0] STEP_W     = DATA_WIDTH'(STEP);
    localparam logic [DATA_WIDTH:0]   MAX_X      = (DATA_WIDTH + 1)'(MAX_VAL);
    localparam logic [DATA_WIDTH:0]   STEP_X     = (DATA_WIDTH + 1)'(STEP);
    localparam logic [DATA_WIDTH:0]   FLOOR_TRIG = (DATA_WIDTH + 1)'(MIN_VAL + STEP);

    logic                  tick;
    logic [DATA_WIDTH-1:0] sample_q, sample_d;
    logic [DATA_WIDTH:0]   sum;
    dir_e                  dir_q, dir_d;

`ifdef VERILOG_TASK_TRIANGLE_PRESCALER_EN
    verilog_task_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .ref_clk (ref_clk),
        .rstn    (rstn),
        .tick_o  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        sample_d = sample_q;
        dir_d    = dir_q;
        sum      = {1'b0, sample_q} + STEP_X;
        if (tick) begin
            if (dir_q == UP) begin
                if (sum >= MAX_X) begin
                    sample_d = MAX_W;
                    dir_d    = DOWN;
                end else begin
                    sample_d = sum[DATA_WIDTH-1:0];
                end
            // Inclusive compare mirrors the ceiling, so the floor is hit once and never held twice.
            end else if ({1'b0, sample_q} <= FLOOR_TRIG) begin
                sample_d = MIN_W;
                dir_d    = UP;
            end else begin
                sample_d = sample_q - STEP_W;
            end
        end
    end

    always_ff @(posedge ref_clk or posedge rstn) begin
        if (rstn) begin
            sample_q <= MIN_W;
            dir_q    <= UP;
        end else begin
            sample_q <= sample_d;
            dir_q    <= dir_d;
        end
    end

    assign triangle_wave = sample_q;

endmodule

// File: tb/tb_verilog_task_triangle_gen.sv
// Self-checking bench: four generator instances (defaults, uneven step, offset floor, CLK_DIV=4).
module tb_verilog_task_triangle_gen;

`ifdef VERILOG_TASK_TRIANGLE_PRESCALER_EN
    localparam bit PRESC = 1'b1;
`else
    localparam bit PRESC = 1'b0;
`endif

    logic        ref_clk = 1'b0;
    logic        rstn    = 1'b0;
    logic [11:0] w_main, w_ns, w_off, w_div;

    verilog_task_triangle_gen u_main (
        .ref_clk(ref_clk), .rstn(rstn), .triangle_wave(w_main));
    verilog_task_triangle_gen #(.MIN_VAL(0), .MAX_VAL(10), .STEP(4)) u_ns (
        .ref_clk(ref_clk), .rstn(rstn), .triangle_wave(w_ns));
    verilog_task_triangle_gen #(.MIN_VAL(100), .MAX_VAL(103), .STEP(1)) u_off (
        .ref_clk(ref_clk), .rstn(rstn), .triangle_wave(w_off));
    verilog_task_triangle_gen #(.CLK_DIV(4)) u_div (
        .ref_clk(ref_clk), .rstn(rstn), .triangle_wave(w_div));

    always #5 ref_clk = ~ref_clk;

    typedef struct {
        logic [11:0] main_v;
        logic [11:0] ns_v;
        logic [11:0] off_v;
        logic [11:0] div_v;
    } exp_t;

    typedef struct {
        logic rst;
        exp_t exp;
    } vec_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag, input exp_t e);
        check({tag, ".main"}, w_main, e.main_v);
        check({tag, ".ns"},   w_ns,   e.ns_v);
        check({tag, ".off"},  w_off,  e.off_v);
        check({tag, ".div"},  w_div,  e.div_v);
    endtask

    // Push the expectation, let one rising edge pass, then pop and compare.
    task automatic edge_step(input string tag, input exp_t e);
        exp_t got_e;
        sb_q.push_back(e);
        @(posedge ref_clk);
        #1;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got_e = sb_q.pop_front();
            compare_all(tag, got_e);
        end
    endtask

    // Reference values after n update edges since reset release.
    function automatic logic [11:0] f_main(input int n);
        int m = n % 8190;
        return 12'((m <= 4095) ? m : 8190 - m);
    endfunction

    function automatic logic [11:0] f_ns(input int n);
        case (n % 6)
            0: return 12'd0;
            1: return 12'd4;
            2: return 12'd8;
            3: return 12'd10;
            4: return 12'd6;
            default: return 12'd2;
        endcase
    endfunction

    function automatic logic [11:0] f_off(input int n);
        case (n % 6)
            0: return 12'd100;
            1: return 12'd101;
            2: return 12'd102;
            3: return 12'd103;
            4: return 12'd102;
            default: return 12'd101;
        endcase
    endfunction

    function automatic exp_t model(input int n);
        exp_t e;
        e.main_v = f_main(n);
        e.ns_v   = f_ns(n);
        e.off_v  = f_off(n);
        e.div_v  = PRESC ? f_main(n / 4) : f_main(n);
        return e;
    endfunction

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main_seq
        vec_t        vecs[10];
        logic [11:0] div_col[10];
        exp_t        e;
        int          n;
        int          peak_hits;

        div_col = PRESC ? '{12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd1, 12'd1, 12'd1, 12'd1, 12'd2}
                        : '{12'd0, 12'd0, 12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd7, 12'd8};
        vecs[0] = '{1'b1, '{12'd0, 12'd0,  12'd100, 12'd0}};
        vecs[1] = '{1'b1, '{12'd0, 12'd0,  12'd100, 12'd0}};
        vecs[2] = '{1'b0, '{12'd1, 12'd4,  12'd101, 12'd0}};
        vecs[3] = '{1'b0, '{12'd2, 12'd8,  12'd102, 12'd0}};
        vecs[4] = '{1'b0, '{12'd3, 12'd10, 12'd103, 12'd0}};
        vecs[5] = '{1'b0, '{12'd4, 12'd6,  12'd102, 12'd0}};
        vecs[6] = '{1'b0, '{12'd5, 12'd2,  12'd101, 12'd0}};
        vecs[7] = '{1'b0, '{12'd6, 12'd0,  12'd100, 12'd0}};
        vecs[8] = '{1'b0, '{12'd7, 12'd4,  12'd101, 12'd0}};
        vecs[9] = '{1'b0, '{12'd8, 12'd8,  12'd102, 12'd0}};
        for (int i = 0; i < 10; i++) vecs[i].exp.div_v = div_col[i];

        #1 rstn = 1'b1;
        #1 compare_all("reset", '{12'd0, 12'd0, 12'd100, 12'd0});

        for (int i = 0; i < 10; i++) begin
            @(negedge ref_clk);
            rstn = vecs[i].rst;
            edge_step($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Ramp on to 37, then assert reset between clock edges.
        n = 8;
        for (int k = 0; k < 100 && n < 37; k++) begin
            n++;
            edge_step($sformatf("ramp%0d", n), model(n));
        end
        check("pre_reset_37", w_main, 12'd37);
        #1 rstn = 1'b1;
        #1 compare_all("async_reset", '{12'd0, 12'd0, 12'd100, 12'd0});

        // Release and run one full default period plus one edge.
        @(negedge ref_clk);
        rstn = 1'b0;
        peak_hits = 0;
        for (int k = 1; k <= 8191; k++) begin
            e = model(k);
            edge_step($sformatf("edge%0d", k), e);
            if (w_main == 12'd4095) peak_hits++;
        end
        check("peak_4095_once", 12'(peak_hits), 12'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
